// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, types and FSM encoding for the binary32 pack stage
package fp_pkg;

    localparam int BIAS       = 127;
    localparam int EXP_MAX    = 255;
    localparam int EXP_W_DEF  = 10;
    localparam int MANT_W_DEF = 28;

    localparam int MANT_CARRY  = 27;
    localparam int MANT_HIDDEN = 26;
    localparam int MANT_G      = 2;
    localparam int MANT_R      = 1;
    localparam int MANT_S      = 0;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        OUT
    } pack_state_t;

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - combinational round-to-nearest-even and binary32 packing
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int EW     = EXP_W_DEF + 1,
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic                 sign,
    input  logic signed [EW-1:0] exp,
    input  logic [MANT_W-1:0]    mant,
    output logic [31:0]          data,
    output logic [2:0]           flags
);

    localparam logic signed [EW-1:0] EXP_LIM = EW'(EXP_MAX);

    logic                 g, r, s, lsb, up, hid_out, ovf, inexact, uf;
    logic [24:0]          sum;
    logic signed [EW-1:0] exp_rnd;
    fp32_t                res;
    logic                 unused_bits;

    assign unused_bits = mant[MANT_CARRY];

    always_comb begin
        g       = mant[MANT_G];
        r       = mant[MANT_R];
        s       = mant[MANT_S];
        lsb     = mant[MANT_G+1];
        up      = g & (r | s | lsb);
        sum     = {1'b0, mant[MANT_HIDDEN:MANT_G+1]} + {24'b0, up};
        // sum[24] means the round carried past the hidden bit
        exp_rnd = exp + {{(EW-1){1'b0}}, sum[24]};
        hid_out = sum[24] | sum[23];
        ovf     = (mant != '0) && hid_out && (exp_rnd >= EXP_LIM);

        res = '0;
        res.sign = sign;
        if (mant == '0) begin
            res.exp  = 8'h00;
            res.frac = 23'h0;
        end else if (ovf) begin
            res.exp  = 8'hFF;
            res.frac = 23'h0;
        end else begin
            res.exp  = hid_out ? exp_rnd[7:0] : 8'h00;
            res.frac = sum[22:0];
        end

        inexact = g | r | s | ovf;
        uf      = inexact & (res.exp == 8'h00);
        data    = res;
        flags   = {ovf, uf, inexact};
    end

endmodule

// File: rtl/fp_pack.sv
// rtl/fp_pack.sv - normalize/round/pack stage; FP_PACK_FLAGS_EN enables out_flags
module fp_pack
    import fp_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic [MANT_W-1:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data,
    output logic [2:0]              out_flags
);

    // One extra bit so a carry shift at the top of the input range cannot wrap
    localparam int EW = EXP_W + 1;
    localparam logic signed [EXP_W-1:0] EXP_CLAMP = -25;
    localparam logic signed [EW-1:0]    E_ONE     = 1;

    pack_state_t          state;
    logic                 sign_r;
    logic signed [EW-1:0] exp_r;
    logic [MANT_W-1:0]    mant_r;
    logic [31:0]          rnd_data;
    logic [2:0]           rnd_flags;

    fp_round_rne #(
        .EW     (EW),
        .MANT_W (MANT_W)
    ) u_round (
        .sign  (sign_r),
        .exp   (exp_r),
        .mant  (mant_r),
        .data  (rnd_data),
        .flags (rnd_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            mant_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r   <= in_sign;
                        in_ready <= 1'b0;
                        state    <= NORM;
                        // Far-below-range operands collapse to a sticky bit at exp 1
                        if (in_exp < EXP_CLAMP) begin
                            exp_r  <= E_ONE;
                            mant_r <= {{(MANT_W-1){1'b0}}, |in_mant};
                        end else begin
                            exp_r  <= {in_exp[EXP_W-1], in_exp};
                            mant_r <= in_mant;
                        end
                    end
                end
                NORM: begin
                    if (mant_r == '0) begin
                        state <= ROUND;
                    end else if (mant_r[MANT_CARRY] || (exp_r < E_ONE)) begin
                        mant_r <= {1'b0, mant_r[MANT_W-1:2], mant_r[1] | mant_r[0]};
                        exp_r  <= exp_r + E_ONE;
                    end else if (!mant_r[MANT_HIDDEN] && (exp_r > E_ONE)) begin
                        mant_r <= {mant_r[MANT_W-2:0], 1'b0};
                        exp_r  <= exp_r - E_ONE;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    out_data  <= rnd_data;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FP_PACK_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flags <= 3'b0;
        end else if (state == ROUND) begin
            out_flags <= rnd_flags;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = ^rnd_flags;
    assign out_flags    = 3'b0;
`endif

endmodule

// File: tb/tb_fp_pack.sv
// tb/tb_fp_pack.sv - directed-vector bench for fp_pack
module tb_fp_pack;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_sign = 1'b0;
    logic signed [9:0]  in_exp = '0;
    logic [27:0]        in_mant = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [31:0]        out_data;
    logic [2:0]         out_flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] fl(input logic [2:0] f);
`ifdef FP_PACK_FLAGS_EN
        return f;
`else
        return 3'b000 & f;
`endif
    endfunction

    // Accepts one operand and waits for the result; leaves the block in OUT.
    task automatic start_op(input logic s, input int e, input logic [27:0] m, output int lat);
        @(negedge clk);
        in_sign  = s;
        in_exp   = 10'(e);
        in_mant  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input int e, input logic [27:0] m,
                          input logic [31:0] want_data, input logic [2:0] want_flags,
                          input int want_lat);
        int lat;
        start_op(s, e, m, lat);
        check({tag, ".lat"}, 32'(lat), 32'(want_lat));
        check({tag, ".data"}, out_data, want_data);
        check({tag, ".flags"}, {29'b0, out_flags}, {29'b0, fl(want_flags)});
        check({tag, ".busy"}, {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".done"}, {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int lat;
        logic [31:0] held;

        #12;
        check("rst.in_ready", {31'b0, in_ready}, 32'd1);
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.out_data", out_data, 32'h0);
        check("rst.out_flags", {29'b0, out_flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("rnd_up", 1'b0, 129, {2'b01, 23'h5CCCCC, 3'b110}, 32'h40DCCCCD, 3'b001, 2);
        run_op("carry",  1'b0, 127, 28'h8000000,                 32'h40000000, 3'b000, 3);
        run_op("left",   1'b0, 130, 28'h0800000,                 32'h3F800000, 3'b000, 5);
        run_op("tie",    1'b0, 127, {2'b01, 23'h0, 3'b100},      32'h3F800000, 3'b001, 2);
        run_op("ovf",    1'b0, 254, {2'b01, 23'h7FFFFF, 3'b100}, 32'h7F800000, 3'b101, 2);
        run_op("subn",   1'b0, -2,  {2'b01, 23'h0, 3'b000},      32'h00100000, 3'b000, 5);
        run_op("zero",   1'b1, 5,   28'h0,                       32'h80000000, 3'b000, 2);
        run_op("clamp",  1'b0, -30, 28'h4000000,                 32'h00000000, 3'b011, 2);
        run_op("edge25", 1'b0, -25, 28'h4000000,                 32'h00000000, 3'b011, 28);
        run_op("sub2nrm", 1'b0, 1,  {2'b00, 23'h7FFFFF, 3'b100}, 32'h00800000, 3'b001, 2);
        run_op("neg",    1'b1, 128, {2'b01, 23'h0, 3'b101},      32'hC0000001, 3'b001, 2);

        start_op(1'b0, 129, {2'b01, 23'h5CCCCC, 3'b110}, lat);
        held = out_data;
        check("bp.data0", held, 32'h40DCCCCD);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp.data", out_data, 32'h40DCCCCD);
            check("bp.stall", {30'b0, out_valid, in_ready}, 32'b10);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp.done", {30'b0, out_valid, in_ready}, 32'b01);

        @(negedge clk);
        in_sign  = 1'b0;
        in_exp   = 10'(130);
        in_mant  = 28'h0800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstnorm.hs", {30'b0, out_valid, in_ready}, 32'b01);
        check("rstnorm.data", out_data, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        check("rstnorm.drop", {30'b0, out_valid, in_ready}, 32'b01);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("after_rst", 1'b0, 127, 28'h8000000, 32'h40000000, 3'b000, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_pack.md
# fp_pack

Normalize-round-pack stage of the single-precision adder/subtracter: the inverse of the unpack stage. It accepts a sign, a wide signed biased exponent and an extended mantissa with guard/round/sticky bits from the add/sub datapath. It normalizes the mantissa one bit per cycle, rounds to nearest-even and emits a packed IEEE-754 binary32 word over a valid/ready handshake.

## Interface
- `EXP_W`, 10: width of the signed two's-complement biased input exponent.
- `MANT_W`, 28: extended mantissa width, laid out as:
  - [27] carry
  - [26] hidden
  - [25:3] fraction
  - [2] G, [1] R, [0] S
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input operand valid.
- `in_ready`  out  1  block can accept an operand.
- `in_sign`  in  1  result sign.
- `in_exp`  in  EXP_W  signed biased exponent (bias 127).
- `in_mant`  in  MANT_W  extended mantissa.
- `out_valid`  out  1  packed result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  32  packed binary32 {sign, exp[7:0], frac[22:0]}.
- `out_flags`  out  3  {overflow, underflow, inexact}.

## Operation
- States:
  - IDLE: `in_ready`=1. Handshake on `in_valid`&`in_ready` registers the inputs and moves to NORM.
  - NORM: at most one shift per cycle, in this priority:
    - mant==0: go to ROUND.
    - carry bit set: shift right 1, S |= shifted-out bit, exp+1.
    - exp<1: shift right 1 with sticky, exp+1 (gradual underflow).
    - hidden==0 and exp>1: shift left 1, exp−1.
    - otherwise (normalized, or exp==1 subnormal): go to ROUND.
  - ROUND: round to nearest-even and register `out_data`/`out_flags`, then go to OUT.
    - Round up when G & (R|S|lsb).
    - A carry out of the fraction sets the hidden bit (subnormal to normal) or increments exp and clears the fraction.
  - OUT: `out_valid`=1. Handshake on `out_valid`&`out_ready` returns to IDLE.
- Accept-time clamp: if `in_exp` < −25, load exp=1 and mant={25'b0, 2'b0, |in_mant}. This bounds NORM to 28 cycles.
- Pack rules:
  - hidden==0 gives exp field 0 (subnormal or zero).
  - Rounded exp ≥ 255 gives {sign, 8'hFF, 23'b0} and sets overflow.
  - mant==0 gives {in_sign, 31'b0}.
- Flags:
  - inexact = G|R|S at round time.
  - underflow = inexact & exp field 0.
  - overflow also sets inexact.
- `out_data`/`out_flags` hold stable from entry to OUT until the output handshake.

## Timing
- Reset values:
  - state IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `out_data`=32'h0
  - `out_flags`=3'b0
- Latency: `out_valid` rises 2+k cycles after the accept edge, where k = number of shift cycles in NORM (0..28).
- No new operand is accepted until the output handshake completes. Initiation interval is ≥ 4 cycles.
- `out_ready` held low stalls indefinitely in OUT with no data change.
- `rst_n` low at any point, including mid-NORM or mid-OUT, immediately forces reset values. The in-flight operand is discarded.

## Configuration
- `FP_PACK_FLAGS_EN`:
  - Defined: `out_flags` is computed as above.
  - Undefined: `out_flags` is tied to 3'b0 and the flag registers are removed. `out_data` and timing are identical.

## Structure
- Package `fp_pkg`:
  - `BIAS`=127, `EXP_MAX`=255.
  - `EXP_W`/`MANT_W` defaults.
  - Mantissa bit-index constants (CARRY, HIDDEN, G, R, S).
  - `fp32_t` struct {sign, exp, frac}.
  - `pack_state_t` enum {IDLE, NORM, ROUND, OUT}.
- One combinational sub-module, `fp_round_rne`: takes sign, exp, normalized mant and returns packed word plus flags. It is used in the ROUND state.
- The FSM, shifter and handshake stay in `fp_pack`.

## Test plan
- **Round up:** sign 0, exp 129, mant {2'b01, 23'h5CCCCC, 3'b110} -> `out_data` 32'h40DCCCCD (6.9), flags 3'b001, `out_valid` 2 cycles after accept.
- **Carry normalization:** exp 127, mant 28'h8000000 (carry set) -> 32'h40000000, flags 0, latency 3.
- **Left normalization:** exp 130, mant 28'h0800000 -> 3 left shifts -> 32'h3F800000, latency 5.
- **Tie and overflow:**
  - exp 127, mant {2'b01, 23'h0, 3'b100} -> 32'h3F800000, inexact only.
  - exp 254, frac all ones, GRS 100 -> 32'h7F800000, flags 3'b101.
- **Underflow and zero:**
  - exp −2, mant {2'b01, 23'h0, 3'b000} -> subnormal 32'h00100000, flags 0.
  - mant 0 with sign 1 -> 32'h80000000.
- **Backpressure and reset:** hold `out_ready`=0 for 5 cycles -> `out_data` stable, `in_ready`=0. Drop `rst_n` in NORM of the next operand -> `out_valid` 0 and `in_ready` 1 immediately.
